hazard_forward_unit: RTL and testbench

Parametrised successor of the 2-operand forwarding unit for the 5-stage MIPS pipeline. Provides per-operand EX-stage forwarding selects for N_SRC operands and suppresses forwarding from register 0. Adds sequential hazard control:
- load-use stall counter;
- multi-cycle MDU (mul/div) result scoreboard.
Drives the PC/IF-ID hold and ID/EX bubble insertion.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fwd_select.sv | 41 ++++
 rtl/hazard_forward_unit.sv | 173 +++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Constants and types shared by the MIPS pipeline hazard and
//               forwarding logic.
//               REG_ADDR_W : default register address width
//               fwd_sel_t  : 2-bit forwarding select
//               FWD_RF / FWD_MEM / FWD_WB : select encodings
//               REG_ZERO   : hard-wired zero register index
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;   // operand from register file
    localparam fwd_sel_t FWD_MEM = 2'b10;   // operand from EX/MEM (newest)
    localparam fwd_sel_t FWD_WB  = 2'b01;   // operand from MEM/WB

    localparam int REG_ZERO = 0;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
// Module      : fwd_select
// Description : Forwarding select for one EX-stage source operand.
//               EX/MEM wins over MEM/WB; register 0 is never forwarded.
// Ports       : src              in  EX-stage source register
//               ex_mem_rd/_we    in  MEM-stage destination / write enable
//               mem_wb_rd/_we    in  WB-stage destination / write enable
//               sel              out 00 reg file, 10 EX/MEM, 01 MEM/WB
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_select
    import mips_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] ex_mem_rd,
    input  logic              ex_mem_reg_write,
    input  logic [ADDR_W-1:0] mem_wb_rd,
    input  logic              mem_wb_reg_write,
    output logic [1:0]        sel
);

    localparam logic [ADDR_W-1:0] c_zero = ADDR_W'(REG_ZERO);

    fwd_sel_t w_sel;

    always_comb begin
        w_sel = FWD_RF;
        if (ex_mem_reg_write && (ex_mem_rd != c_zero) && (ex_mem_rd == src)) begin
            w_sel = FWD_MEM;
        end else if (mem_wb_reg_write && (mem_wb_rd != c_zero) && (mem_wb_rd == src)) begin
            w_sel = FWD_WB;
        end
    end

    assign sel = w_sel;

endmodule : fwd_select
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_unit
// Description : EX-stage forwarding selects for N_SRC operands plus
//               load-use and MDU-scoreboard stall control for a 5-stage
//               MIPS pipeline.
// Ports       : clk, rst (async, active-high)
//               id_src/id_src_valid       ID source regs and read flags
//               id_is_mdu/id_mdu_rd       ID MDU op and its destination
//               id_ex_src                 EX source regs (forwarding)
//               id_ex_rd/_reg_write/_mem_read  EX instruction info
//               ex_mem_rd/_reg_write      MEM destination
//               mem_wb_rd/_reg_write      WB destination
//               forward_sel  out  2 bits per channel
//               stall        out  hold PC and IF/ID
//               id_ex_flush  out  bubble into ID/EX (equals stall)
//               mdu_busy     out  MDU scoreboard entry live
// Option      : HAZARD_PERF_CNT_EN adds saturating stall_cycles and
//               mdu_stall_cycles counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int N_SRC      = 2,
    parameter int LOAD_DELAY = 1,
    parameter int MDU_LAT    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [N_SRC-1:0]            id_src_valid,
    input  logic                        id_is_mdu,
    input  logic [REG_ADDR_W-1:0]       id_mdu_rd,
    input  logic [N_SRC*REG_ADDR_W-1:0] id_ex_src,
    input  logic [REG_ADDR_W-1:0]       id_ex_rd,
    input  logic                        id_ex_reg_write,
    input  logic                        id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0]       ex_mem_rd,
    input  logic                        ex_mem_reg_write,
    input  logic [REG_ADDR_W-1:0]       mem_wb_rd,
    input  logic                        mem_wb_reg_write,
    output logic [2*N_SRC-1:0]          forward_sel,
    output logic                        stall,
    output logic                        id_ex_flush,
    output logic                        mdu_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                 stall_cycles,
    output logic [31:0]                 mdu_stall_cycles
`endif
);

    import mips_pkg::*;

    localparam int LD_CNT_W  = $clog2(LOAD_DELAY + 1);
    localparam int MDU_CNT_W = $clog2(MDU_LAT + 1);

    localparam logic [LD_CNT_W-1:0]   c_ld_reload  = LD_CNT_W'(LOAD_DELAY - 1);
    localparam logic [MDU_CNT_W-1:0]  c_mdu_reload = MDU_CNT_W'(MDU_LAT - 1);
    localparam logic [REG_ADDR_W-1:0] c_zero       = REG_ADDR_W'(REG_ZERO);

    logic [LD_CNT_W-1:0]   r_ld_cnt;
    logic [MDU_CNT_W-1:0]  r_mdu_cnt;
    logic [REG_ADDR_W-1:0] r_mdu_rd_q;

    logic w_ld_src_match;
    logic w_mdu_src_match;
    logic w_ld_hit;
    logic w_mdu_hit;
    logic w_mdu_busy;
    logic w_stall;
    logic w_mdu_issue;

    // ------------------------------------------------------------------
    // Forwarding: one independent selector per EX operand
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_fwd
            fwd_select #(
                .ADDR_W (REG_ADDR_W)
            ) u_fwd_select (
                .src              (id_ex_src[gi*REG_ADDR_W +: REG_ADDR_W]),
                .ex_mem_rd        (ex_mem_rd),
                .ex_mem_reg_write (ex_mem_reg_write),
                .mem_wb_rd        (mem_wb_rd),
                .mem_wb_reg_write (mem_wb_reg_write),
                .sel              (forward_sel[2*gi +: 2])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Source matching against the loading EX instruction and the
    // outstanding MDU destination; unread operands never match.
    // ------------------------------------------------------------------
    always_comb begin
        w_ld_src_match  = 1'b0;
        w_mdu_src_match = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (id_src_valid[i] && (id_src[i*REG_ADDR_W +: REG_ADDR_W] == id_ex_rd)) begin
                w_ld_src_match = 1'b1;
            end
            if (id_src_valid[i] && (id_src[i*REG_ADDR_W +: REG_ADDR_W] == r_mdu_rd_q)) begin
                w_mdu_src_match = 1'b1;
            end
        end
    end

    assign w_ld_hit   = id_ex_mem_read && id_ex_reg_write && (id_ex_rd != c_zero) && w_ld_src_match;
    assign w_mdu_busy = (r_mdu_cnt != '0);
    // Second term is the structural hazard: only one MDU op in flight.
    assign w_mdu_hit  = w_mdu_busy && ((w_mdu_src_match && (r_mdu_rd_q != c_zero)) || id_is_mdu);
    assign w_stall    = w_ld_hit || (r_ld_cnt != '0) || w_mdu_hit;
    // A stalled MDU op stays in ID and is not issued.
    assign w_mdu_issue = id_is_mdu && !w_stall;

    assign stall       = w_stall;
    assign id_ex_flush = w_stall;
    assign mdu_busy    = w_mdu_busy;

    // ------------------------------------------------------------------
    // Load-use counter: the hit cycle itself is the first stall cycle,
    // so only LOAD_DELAY-1 extra cycles are counted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_cnt <= '0;
        end else if (r_ld_cnt != '0) begin
            r_ld_cnt <= r_ld_cnt - 1'b1;
        end else if (w_ld_hit) begin
            r_ld_cnt <= c_ld_reload;
        end
    end

    // ------------------------------------------------------------------
    // MDU scoreboard (single entry)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mdu_cnt  <= '0;
            r_mdu_rd_q <= '0;
        end else if (w_mdu_issue) begin
            r_mdu_cnt  <= c_mdu_reload;
            r_mdu_rd_q <= id_mdu_rd;
        end else if (r_mdu_cnt != '0) begin
            r_mdu_cnt  <= r_mdu_cnt - 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_mdu_stall_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles     <= '0;
            r_mdu_stall_cycles <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_mdu_hit && (r_mdu_stall_cycles != '1)) begin
                r_mdu_stall_cycles <= r_mdu_stall_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles     = r_stall_cycles;
    assign mdu_stall_cycles = r_mdu_stall_cycles;
`endif

endmodule : hazard_forward_unit
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_forward_unit
// Description : Self-checking bench for hazard_forward_unit. Two instances
//               share stimulus: u_dut1 (LOAD_DELAY=1) and u_dut3
//               (LOAD_DELAY=3), both N_SRC=2, MDU_LAT=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] id_src;
    logic [1:0] id_src_valid;
    logic       id_is_mdu;
    logic [4:0] id_mdu_rd;
    logic [9:0] id_ex_src;
    logic [4:0] id_ex_rd;
    logic       id_ex_reg_write;
    logic       id_ex_mem_read;
    logic [4:0] ex_mem_rd;
    logic       ex_mem_reg_write;
    logic [4:0] mem_wb_rd;
    logic       mem_wb_reg_write;

    logic [3:0] fwd1, fwd3;
    logic       stall1, stall3, flush1, flush3, busy1, busy3;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc1, sc3, msc1, msc3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_ADDR_W(5), .N_SRC(2), .LOAD_DELAY(1), .MDU_LAT(4)) u_dut1 (
        .clk(clk), .rst(rst), .id_src(id_src), .id_src_valid(id_src_valid),
        .id_is_mdu(id_is_mdu), .id_mdu_rd(id_mdu_rd), .id_ex_src(id_ex_src),
        .id_ex_rd(id_ex_rd), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_mem_read(id_ex_mem_read), .ex_mem_rd(ex_mem_rd),
        .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_rd(mem_wb_rd),
        .mem_wb_reg_write(mem_wb_reg_write), .forward_sel(fwd1),
        .stall(stall1), .id_ex_flush(flush1), .mdu_busy(busy1)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc1), .mdu_stall_cycles(msc1)
`endif
    );

    hazard_forward_unit #(.REG_ADDR_W(5), .N_SRC(2), .LOAD_DELAY(3), .MDU_LAT(4)) u_dut3 (
        .clk(clk), .rst(rst), .id_src(id_src), .id_src_valid(id_src_valid),
        .id_is_mdu(id_is_mdu), .id_mdu_rd(id_mdu_rd), .id_ex_src(id_ex_src),
        .id_ex_rd(id_ex_rd), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_mem_read(id_ex_mem_read), .ex_mem_rd(ex_mem_rd),
        .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_rd(mem_wb_rd),
        .mem_wb_reg_write(mem_wb_reg_write), .forward_sel(fwd3),
        .stall(stall3), .id_ex_flush(flush3), .mdu_busy(busy3)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc3), .mdu_stall_cycles(msc3)
`endif
    );

    typedef struct {
        logic [9:0] src;
        logic [1:0] vld;
        logic [9:0] ex_src;
        logic [4:0] exm_rd;
        logic       exm_we;
        logic [4:0] wb_rd;
        logic       wb_we;
        logic [4:0] ex_rd;
        logic       ex_we;
        logic       ex_ld;
        logic [3:0] exp_fwd;
        logic       exp_stall;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clr_inputs();
        id_src           = '0;
        id_src_valid     = '0;
        id_is_mdu        = 1'b0;
        id_mdu_rd        = '0;
        id_ex_src        = '0;
        id_ex_rd         = '0;
        id_ex_reg_write  = 1'b0;
        id_ex_mem_read   = 1'b0;
        ex_mem_rd        = '0;
        ex_mem_reg_write = 1'b0;
        mem_wb_rd        = '0;
        mem_wb_reg_write = 1'b0;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n1, n3, f3, n;
        logic seen;

        // ---------------- vector table (checked on u_dut1) ----------------
        //        src           vld    ex_src          exm_rd we    wb_rd  we    ex_rd  we    ld    fwd      stall
        vt[0]  = '{10'd0,        2'b00, {5'd0, 5'd5},   5'd5, 1'b1, 5'd5,  1'b1, 5'd0, 1'b0, 1'b0, 4'b0010, 1'b0};
        vt[1]  = '{10'd0,        2'b00, {5'd0, 5'd5},   5'd5, 1'b0, 5'd5,  1'b1, 5'd0, 1'b0, 1'b0, 4'b0001, 1'b0};
        vt[2]  = '{10'd0,        2'b00, {5'd0, 5'd0},   5'd0, 1'b1, 5'd0,  1'b1, 5'd0, 1'b0, 1'b0, 4'b0000, 1'b0};
        vt[3]  = '{10'd0,        2'b00, {5'd7, 5'd3},   5'd7, 1'b1, 5'd3,  1'b1, 5'd0, 1'b0, 1'b0, 4'b1001, 1'b0};
        vt[4]  = '{10'd0,        2'b00, {5'd12, 5'd12}, 5'd4, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 4'b0101, 1'b0};
        vt[5]  = '{10'd0,        2'b00, {5'd0, 5'd6},   5'd1, 1'b1, 5'd6,  1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 1'b0};
        vt[6]  = '{{5'd8, 5'd0}, 2'b10, 10'd0,          5'd0, 1'b0, 5'd0,  1'b0, 5'd8, 1'b1, 1'b1, 4'b0000, 1'b1};
        vt[7]  = '{{5'd8, 5'd0}, 2'b01, 10'd0,          5'd0, 1'b0, 5'd0,  1'b0, 5'd8, 1'b1, 1'b1, 4'b0000, 1'b0};
        vt[8]  = '{{5'd0, 5'd0}, 2'b11, 10'd0,          5'd0, 1'b0, 5'd0,  1'b0, 5'd0, 1'b1, 1'b1, 4'b0000, 1'b0};
        vt[9]  = '{{5'd8, 5'd0}, 2'b10, 10'd0,          5'd0, 1'b0, 5'd0,  1'b0, 5'd8, 1'b1, 1'b0, 4'b0000, 1'b0};
        vt[10] = '{{5'd0, 5'd8}, 2'b01, 10'd0,          5'd0, 1'b0, 5'd0,  1'b0, 5'd8, 1'b1, 1'b1, 4'b0000, 1'b1};
        vt[11] = '{{5'd8, 5'd0}, 2'b10, 10'd0,          5'd0, 1'b0, 5'd0,  1'b0, 5'd8, 1'b0, 1'b1, 4'b0000, 1'b0};

        // ---------------- reset state ----------------
        clr_inputs();
        rst = 1'b1;
        #1;
        chk("rst_stall1", {31'd0, stall1}, 32'd0);
        chk("rst_flush1", {31'd0, flush1}, 32'd0);
        chk("rst_busy1",  {31'd0, busy1},  32'd0);
        chk("rst_busy3",  {31'd0, busy3},  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---------------- table-driven combinational checks ----------------
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            id_src           = vt[i].src;
            id_src_valid     = vt[i].vld;
            id_ex_src        = vt[i].ex_src;
            ex_mem_rd        = vt[i].exm_rd;
            ex_mem_reg_write = vt[i].exm_we;
            mem_wb_rd        = vt[i].wb_rd;
            mem_wb_reg_write = vt[i].wb_we;
            id_ex_rd         = vt[i].ex_rd;
            id_ex_reg_write  = vt[i].ex_we;
            id_ex_mem_read   = vt[i].ex_ld;
            @(negedge clk);
            chk($sformatf("vec%0d_fwd", i),   {28'd0, fwd1},   {28'd0, vt[i].exp_fwd});
            chk($sformatf("vec%0d_stall", i), {31'd0, stall1}, {31'd0, vt[i].exp_stall});
            chk($sformatf("vec%0d_flush", i), {31'd0, flush1}, {31'd0, vt[i].exp_stall});
        end

        // ---------------- load-use stall length (1 and 3 cycles) ----------------
        do_reset();
        id_src          = {5'd8, 5'd0};
        id_src_valid    = 2'b10;
        id_ex_rd        = 5'd8;
        id_ex_reg_write = 1'b1;
        id_ex_mem_read  = 1'b1;
        n1 = 0; n3 = 0; f3 = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n1 += int'(stall1);
            n3 += int'(stall3);
            f3 += int'(flush3);
            @(posedge clk);
            #1;
            // the load moves on; a bubble now sits in EX
            id_ex_mem_read  = 1'b0;
            id_ex_reg_write = 1'b0;
            id_ex_rd        = 5'd0;
        end
        chk("ld_stall_cycles_d1", n1, 32'd1);
        chk("ld_stall_cycles_d3", n3, 32'd3);
        chk("ld_flush_cycles_d3", f3, 32'd3);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall_d1", sc1, 32'd1);
        chk("perf_stall_d3", sc3, 32'd3);
`endif

        // ---------------- invalid source: no stall ----------------
        do_reset();
        id_src          = {5'd8, 5'd0};
        id_src_valid    = 2'b01;
        id_ex_rd        = 5'd8;
        id_ex_reg_write = 1'b1;
        id_ex_mem_read  = 1'b1;
        n1 = 0; n3 = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n1 += int'(stall1);
            n3 += int'(stall3);
        end
        chk("inv_src_stall_d1", n1, 32'd0);
        chk("inv_src_stall_d3", n3, 32'd0);

        // ---------------- MDU dependency ----------------
        do_reset();
        id_is_mdu = 1'b1;
        id_mdu_rd = 5'd9;
        @(negedge clk);
        chk("mdu_pre_stall", {31'd0, stall1}, 32'd0);
        chk("mdu_pre_busy",  {31'd0, busy1},  32'd0);
        @(posedge clk);
        #1;
        id_is_mdu    = 1'b0;
        id_src       = {5'd0, 5'd9};
        id_src_valid = 2'b01;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) chk("mdu_busy_after_issue", {31'd0, busy1}, 32'd1);
            n += int'(stall1);
        end
        chk("mdu_dep_stall_cycles", n, 32'd3);
        chk("mdu_busy_dropped", {31'd0, busy1}, 32'd0);
        id_ex_src        = {5'd0, 5'd9};
        mem_wb_rd        = 5'd9;
        mem_wb_reg_write = 1'b1;
        #1;
        chk("mdu_result_fwd_wb", {30'd0, fwd1[1:0]}, 32'd1);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_mdu_stall", msc1, 32'd3);
`endif

        // ---------------- back-to-back MDU (structural) ----------------
        do_reset();
        id_is_mdu = 1'b1;
        id_mdu_rd = 5'd9;
        @(posedge clk);
        #1;
        id_mdu_rd = 5'd10;
        n = 0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!stall1) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        chk("mdu_struct_released", {31'd0, seen}, 32'd1);
        chk("mdu_struct_stall_cycles", n, 32'd3);
        @(posedge clk);
        #1;
        id_is_mdu    = 1'b0;
        id_src       = {5'd0, 5'd10};
        id_src_valid = 2'b01;
        #1;
        chk("mdu_second_busy", {31'd0, busy1}, 32'd1);
        chk("mdu_second_rd_dep", {31'd0, stall1}, 32'd1);
        id_src = {5'd0, 5'd9};
        #1;
        chk("mdu_old_rd_nodep", {31'd0, stall1}, 32'd0);

        // ---------------- async reset during a load stall ----------------
        do_reset();
        id_is_mdu = 1'b1;
        id_mdu_rd = 5'd9;
        @(posedge clk);
        #1;
        id_is_mdu       = 1'b0;
        id_src          = {5'd8, 5'd0};
        id_src_valid    = 2'b10;
        id_ex_rd        = 5'd8;
        id_ex_reg_write = 1'b1;
        id_ex_mem_read  = 1'b1;
        @(posedge clk);
        #1;
        id_ex_mem_read  = 1'b0;
        id_ex_reg_write = 1'b0;
        id_ex_rd        = 5'd0;
        id_src_valid    = 2'b00;
        #1;
        chk("arst_pre_stall3", {31'd0, stall3}, 32'd1);
        chk("arst_pre_busy3",  {31'd0, busy3},  32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_stall3", {31'd0, stall3}, 32'd0);
        chk("arst_flush3", {31'd0, flush3}, 32'd0);
        chk("arst_busy3",  {31'd0, busy3},  32'd0);
        chk("arst_busy1",  {31'd0, busy1},  32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("arst_perf_stall3", sc3, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("arst_after_stall3", {31'd0, stall3}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_forward_unit
`default_nettype wire
